// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder
// NEC infrared frame decoder running on a 125 us clock-enable tick derived
// from sys_clk. Raw input is synchronised and majority-free filtered (all
// FILT_LEN samples must agree), then an FSM measures mark/space lengths in
// ticks and reports frames, repeat codes and coded errors.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting for a filtered fall (start of leader mark)
// S_LEAD_LOW   | 9 ms leader mark, expecting rise at 69..75 ticks
// S_LEAD_HIGH  | leader space: 33..38 -> data, 15..20 -> repeat code
// S_BIT_LOW    | 562 us bit mark (or stop mark once 32 bits are in)
// S_BIT_HIGH   | bit space: 2..6 ticks = 0, 10..15 ticks = 1
// S_RPT_STOP   | stop mark that ends a repeat code
module nec_ir_decoder #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FILT_LEN   = 3,
  parameter int EXT_ADDR   = 0,
  parameter int REPEAT_WIN = 880
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        remote_in,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        busy
);

  localparam int CLK_DIV = CLK_FREQ / 8000;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int RPT_W   = $clog2(REPEAT_WIN + 1);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_WIN);

  localparam logic [1:0] E_TIMING = 2'd1;
  localparam logic [1:0] E_CHKSUM = 2'd2;
  localparam logic [1:0] E_ORPHAN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_LOW,
    S_LEAD_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_RPT_STOP
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic                sync_q1, sync_q2;
  logic [FILT_LEN-1:0] samp_next;
  logic                all1, all0;
  logic                filt;
  logic                rise_evt, fall_evt;
  logic [7:0]          phase, ph;
  logic [5:0]          bit_idx, idx_nxt;
  logic [31:0]         shreg, sr_nxt;
  logic [RPT_W-1:0]    rpt_tmr;
  logic                rpt_load;
  logic                t_err;
  logic                fv_nxt, rv_nxt, err_nxt;
  logic [1:0]          code_nxt;
  logic [15:0]         addr_nxt;
  logic [7:0]          cmd_nxt;
  logic [7:0]          b0, b1, b2, b3;
  logic                frame_ok;

  // Tick divider: one-cycle tick every CLK_DIV sys_clk cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= remote_in;
      sync_q2 <= sync_q1;
    end
  end

  // The newest sample is the synchroniser output itself, so only FILT_LEN-1
  // older samples need storage; the agreement check sees all FILT_LEN.
  generate
    if (FILT_LEN == 1) begin : g_filt_one
      assign samp_next = sync_q2;
    end else begin : g_filt_hist
      logic [FILT_LEN-2:0] hist;
      // Sample history, shifted once per tick.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          hist <= '1;
        end else if (tick) begin
          hist <= samp_next[FILT_LEN-2:0];
        end
      end
      assign samp_next = {hist, sync_q2};
    end
  endgenerate

  assign all1     = &samp_next;
  assign all0     = ~|samp_next;
  assign fall_evt = tick & filt & all0;
  assign rise_evt = tick & ~filt & all1;

  // Filtered level moves only when every sample agrees.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      filt <= 1'b1;
    end else if (tick) begin
      if (all1) begin
        filt <= 1'b1;
      end else if (all0) begin
        filt <= 1'b0;
      end
    end
  end

  // ph is the tick distance from the last filtered edge to this tick.
  assign ph = (phase == 8'hFF) ? 8'hFF : phase + 8'd1;

  // Phase counter: saturating tick count, cleared on every filtered edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase <= '0;
    end else if (tick) begin
      if (rise_evt || fall_evt) begin
        phase <= '0;
      end else begin
        phase <= ph;
      end
    end
  end

  // Repeat window timer; a reload beats the per-tick decrement.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rpt_tmr <= '0;
    end else if (rpt_load) begin
      rpt_tmr <= RPT_LOAD;
    end else if (tick && (rpt_tmr != '0)) begin
      rpt_tmr <= rpt_tmr - RPT_W'(1);
    end
  end

  assign b0 = shreg[7:0];
  assign b1 = shreg[15:8];
  assign b2 = shreg[23:16];
  assign b3 = shreg[31:24];
  assign frame_ok = (b3 == ~b2) && ((EXT_ADDR != 0) || (b1 == ~b0));

  // FSM state register plus decoded data and registered output pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      bit_idx      <= '0;
      shreg        <= '0;
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
      addr         <= '0;
      cmd          <= '0;
    end else begin
      state        <= state_nxt;
      bit_idx      <= idx_nxt;
      shreg        <= sr_nxt;
      frame_valid  <= fv_nxt;
      repeat_valid <= rv_nxt;
      err          <= err_nxt;
      err_code     <= code_nxt;
      addr         <= addr_nxt;
      cmd          <= cmd_nxt;
    end
  end

  // Next-state and output decode; decisions are taken on tick cycles only.
  always_comb begin
    state_nxt = state;
    idx_nxt   = bit_idx;
    sr_nxt    = shreg;
    fv_nxt    = 1'b0;
    rv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    addr_nxt  = addr;
    cmd_nxt   = cmd;
    rpt_load  = 1'b0;
    t_err     = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (fall_evt) begin
            state_nxt = S_LEAD_LOW;
          end
        end
        S_LEAD_LOW: begin
          if (rise_evt) begin
            if (ph >= 8'd69 && ph <= 8'd75) begin
              state_nxt = S_LEAD_HIGH;
            end else begin
              t_err = 1'b1;
            end
          end else if (ph >= 8'd76) begin
            t_err = 1'b1;
          end
        end
        S_LEAD_HIGH: begin
          if (fall_evt) begin
            if (ph >= 8'd33 && ph <= 8'd38) begin
              state_nxt = S_BIT_LOW;
              idx_nxt   = '0;
              sr_nxt    = '0;
            end else if (ph >= 8'd15 && ph <= 8'd20) begin
              state_nxt = S_RPT_STOP;
            end else begin
              t_err = 1'b1;
            end
          end else if (ph >= 8'd39) begin
            t_err = 1'b1;
          end
        end
        S_BIT_LOW: begin
          if (rise_evt) begin
            if (ph >= 8'd2 && ph <= 8'd6) begin
              if (bit_idx < 6'd32) begin
                state_nxt = S_BIT_HIGH;
              end else if (frame_ok) begin
                state_nxt = S_IDLE;
                fv_nxt    = 1'b1;
                rpt_load  = 1'b1;
                addr_nxt  = (EXT_ADDR != 0) ? {b1, b0} : {8'h00, b0};
                cmd_nxt   = b2;
              end else begin
                state_nxt = S_IDLE;
                err_nxt   = 1'b1;
                code_nxt  = E_CHKSUM;
                sr_nxt    = '0;
              end
            end else begin
              t_err = 1'b1;
            end
          end else if (ph >= 8'd7) begin
            t_err = 1'b1;
          end
        end
        S_BIT_HIGH: begin
          if (fall_evt) begin
            if (ph >= 8'd2 && ph <= 8'd6) begin
              sr_nxt    = {1'b0, shreg[31:1]};
              idx_nxt   = bit_idx + 6'd1;
              state_nxt = S_BIT_LOW;
            end else if (ph >= 8'd10 && ph <= 8'd15) begin
              sr_nxt    = {1'b1, shreg[31:1]};
              idx_nxt   = bit_idx + 6'd1;
              state_nxt = S_BIT_LOW;
            end else begin
              t_err = 1'b1;
            end
          end else if (ph >= 8'd16) begin
            t_err = 1'b1;
          end
        end
        S_RPT_STOP: begin
          if (rise_evt) begin
            if (ph >= 8'd2 && ph <= 8'd6) begin
              state_nxt = S_IDLE;
              if (rpt_tmr != '0) begin
                rv_nxt   = 1'b1;
                rpt_load = 1'b1;
              end else begin
                err_nxt  = 1'b1;
                code_nxt = E_ORPHAN;
                sr_nxt   = '0;
              end
            end else begin
              t_err = 1'b1;
            end
          end else if (ph >= 8'd7) begin
            t_err = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
      if (t_err) begin
        state_nxt = S_IDLE;
        err_nxt   = 1'b1;
        code_nxt  = E_TIMING;
        sr_nxt    = '0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb_nec_ir_decoder
// Two decoders share one IR line: u_a (FILT_LEN=3, 8-bit address) and
// u_b (FILT_LEN=1, 16-bit address). Stimulus tasks push the expected
// events per decoder into queues; monitors pop and compare on each pulse.
`timescale 1ns/1ps
module tb_nec_ir_decoder;

  localparam int CLK_FREQ = 32_000;
  localparam int DIV      = CLK_FREQ / 8000;
  localparam int WIN      = 880;
  localparam int TICK_NS  = DIV * 10;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic remote_in = 1'b1;

  logic a_fv, a_rv, a_err, a_busy;
  logic [1:0]  a_code;
  logic [15:0] a_addr;
  logic [7:0]  a_cmd;
  logic b_fv, b_rv, b_err, b_busy;
  logic [1:0]  b_code;
  logic [15:0] b_addr;
  logic [7:0]  b_cmd;

  typedef struct {
    int kind;   // 0 frame, 1 repeat, 2 error
    int code;
    int addr;
    int cmd;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];

  int     vectors     = 0;
  int     miscompares = 0;
  int     m_addr[2];
  int     m_cmd[2];
  longint m_last[2];
  int     m_ext[2]  = '{0, 1};
  int     m_filt[2] = '{3, 1};

  always #5 sys_clk = ~sys_clk;

  nec_ir_decoder #(.CLK_FREQ(CLK_FREQ), .FILT_LEN(3), .EXT_ADDR(0), .REPEAT_WIN(WIN)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .remote_in(remote_in),
    .frame_valid(a_fv), .repeat_valid(a_rv), .err(a_err), .err_code(a_code),
    .addr(a_addr), .cmd(a_cmd), .busy(a_busy));

  nec_ir_decoder #(.CLK_FREQ(CLK_FREQ), .FILT_LEN(1), .EXT_ADDR(1), .REPEAT_WIN(WIN)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .remote_in(remote_in),
    .frame_valid(b_fv), .repeat_valid(b_rv), .err(b_err), .err_code(b_code),
    .addr(b_addr), .cmd(b_cmd), .busy(b_busy));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint now_tick();
    longint t;
    t = longint'($time);
    return t / TICK_NS;
  endfunction

  task automatic push_ev(input int d, input int kind, input int code);
    ev_t e;
    e.kind = kind;
    e.code = code;
    e.addr = m_addr[d];
    e.cmd  = m_cmd[d];
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic mon(input int d, input logic fv, input logic rv, input logic er,
                     input logic [1:0] code, input logic [15:0] ad, input logic [7:0] cm);
    ev_t   e;
    int    kind;
    string tag;
    tag  = (d == 0) ? "a" : "b";
    kind = fv ? 0 : (rv ? 1 : 2);
    check({tag, "_pulse_count"}, int'(fv) + int'(rv) + int'(er), 1);
    vectors++;
    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
      miscompares++;
      $display("FAIL %s_unexpected: got event kind %0d, want no event", tag, kind);
      return;
    end
    if (d == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
    check({tag, "_kind"}, kind, e.kind);
    check({tag, "_addr"}, int'(ad), e.addr);
    check({tag, "_cmd"}, int'(cm), e.cmd);
    if (kind == 2) check({tag, "_err_code"}, int'(code), e.code);
  endtask

  // Monitors sample on the falling edge, away from the decoder's clock edge.
  always @(negedge sys_clk)
    if (sys_rst_n && (a_fv || a_rv || a_err)) mon(0, a_fv, a_rv, a_err, a_code, a_addr, a_cmd);

  always @(negedge sys_clk)
    if (sys_rst_n && (b_fv || b_rv || b_err)) mon(1, b_fv, b_rv, b_err, b_code, b_addr, b_cmd);

  task automatic hold(input logic lvl, input int ticks);
    remote_in = lvl;
    repeat (ticks * DIV) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b0, 4 + int'($urandom_range(0, 1)));
      hold(1'b1, w[i] ? 13 + int'($urandom_range(0, 1)) : 4 + int'($urandom_range(0, 1)));
    end
  endtask

  // w = {b3, b2, b1, b0}; glitch puts a one-tick low inside the leader space.
  task automatic send_frame(input logic [31:0] w, input bit glitch);
    bit pass[2];
    for (int d = 0; d < 2; d++) begin
      pass[d] = 1'b0;
      if (glitch && m_filt[d] == 1) begin
        // glitch itself, then each of the 33 following marks looks like a
        // far-too-short leader
        for (int k = 0; k < 34; k++) push_ev(d, 2, 1);
      end else begin
        pass[d] = (w[31:24] == ~w[23:16]) && (m_ext[d] == 1 || w[15:8] == ~w[7:0]);
        if (pass[d]) begin
          m_addr[d] = (m_ext[d] == 1) ? int'(w[15:0]) : int'(w[7:0]);
          m_cmd[d]  = int'(w[23:16]);
          push_ev(d, 0, 0);
        end else begin
          push_ev(d, 2, 2);
        end
      end
    end
    hold(1'b0, 72);
    if (glitch) begin
      hold(1'b1, 10);
      hold(1'b0, 1);
      hold(1'b1, 25);
    end else begin
      hold(1'b1, 36);
    end
    send_bits(w, 32);
    hold(1'b0, 4 + int'($urandom_range(0, 1)));
    remote_in = 1'b1;
    for (int d = 0; d < 2; d++) if (pass[d]) m_last[d] = now_tick();
    hold(1'b1, 30);
  endtask

  task automatic send_repeat();
    int     stop_t;
    longint end_t;
    bit     acc[2];
    bit     near_edge;
    stop_t = 4 + int'($urandom_range(0, 1));
    // keep the repeat clear of the window boundary so the outcome is certain
    do begin
      end_t = now_tick() + 72 + 18 + stop_t;
      near_edge = 1'b0;
      for (int d = 0; d < 2; d++)
        if (m_last[d] >= 0 && end_t - m_last[d] > WIN - 25 && end_t - m_last[d] < WIN + 25)
          near_edge = 1'b1;
      if (near_edge) hold(1'b1, 10);
    end while (near_edge);
    for (int d = 0; d < 2; d++) begin
      acc[d] = (m_last[d] >= 0) && (end_t - m_last[d] < WIN);
      if (acc[d]) push_ev(d, 1, 0);
      else        push_ev(d, 2, 3);
    end
    hold(1'b0, 72);
    hold(1'b1, 18);
    hold(1'b0, stop_t);
    remote_in = 1'b1;
    for (int d = 0; d < 2; d++) if (acc[d]) m_last[d] = now_tick();
    hold(1'b1, 30);
  endtask

  task automatic check_zero(input string tag, input logic [15:0] ad, input logic [7:0] cm,
                            input logic [1:0] code, input logic bz);
    check({tag, "_rst_addr"}, int'(ad), 0);
    check({tag, "_rst_cmd"}, int'(cm), 0);
    check({tag, "_rst_err_code"}, int'(code), 0);
    check({tag, "_rst_busy"}, int'(bz), 0);
  endtask

  function automatic logic [31:0] rand_valid();
    logic [7:0] x0, x2;
    x0 = 8'($urandom);
    x2 = 8'($urandom);
    return {~x2, x2, ~x0, x0};
  endfunction

  initial begin
    logic [7:0]  r0, r1, r2, r3;
    logic [31:0] w;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 0;
      m_cmd[d]  = 0;
      m_last[d] = -1;
    end

    repeat (5) @(negedge sys_clk);
    check_zero("a", a_addr, a_cmd, a_code, a_busy);
    check_zero("b", b_addr, b_cmd, b_code, b_busy);
    sys_rst_n = 1'b1;
    hold(1'b1, 20);

    send_frame(32'hBA45_FF00, 1'b0);
    hold(1'b1, 225);
    send_repeat();
    hold(1'b1, 1600);
    send_repeat();
    send_frame(32'hBB45_FF00, 1'b0);

    // leader mark far too short
    for (int d = 0; d < 2; d++) push_ev(d, 2, 1);
    hold(1'b0, 48);
    hold(1'b1, 30);

    // line stuck low for 40 ms
    for (int d = 0; d < 2; d++) push_ev(d, 2, 1);
    hold(1'b0, 20);
    check("a_busy_in_leader", int'(a_busy), 1);
    check("b_busy_in_leader", int'(b_busy), 1);
    hold(1'b0, 300);
    check("a_busy_after_timeout", int'(a_busy), 0);
    check("b_busy_after_timeout", int'(b_busy), 0);
    hold(1'b1, 30);

    send_frame(32'h3DC2_E51A, 1'b1);
    send_frame(32'hF30C_1234, 1'b0);

    for (int it = 0; it < 8; it++) begin
      r0 = 8'($urandom);
      r1 = ($urandom_range(0, 3) != 0) ? ~r0 : 8'($urandom);
      r2 = 8'($urandom);
      r3 = ($urandom_range(0, 3) != 0) ? ~r2 : (~r2 ^ (8'h01 << $urandom_range(0, 7)));
      send_frame({r3, r2, r1, r0}, 1'b0);
      case ($urandom_range(0, 2))
        0: ;
        1: begin hold(1'b1, int'($urandom_range(100, 400))); send_repeat(); end
        default: begin hold(1'b1, int'($urandom_range(950, 1100))); send_repeat(); end
      endcase
    end

    // reset in the middle of bit 17
    w = rand_valid();
    hold(1'b0, 72);
    hold(1'b1, 36);
    send_bits(w, 17);
    remote_in = 1'b0;
    repeat (2 * DIV) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_zero("a", a_addr, a_cmd, a_code, a_busy);
    check_zero("b", b_addr, b_cmd, b_code, b_busy);
    remote_in = 1'b1;
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = 0;
      m_cmd[d]  = 0;
      m_last[d] = -1;
    end
    hold(1'b1, 30);
    send_frame(w, 1'b0);
    send_repeat();

    for (int i = 0; i < 400 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge sys_clk);
    check("a_pending_events", q_a.size(), 0);
    check("b_pending_events", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Parametrised NEC infrared frame decoder, successor to the team's fixed 50 MHz remote receiver. It runs entirely in the `sys_clk` domain using a clock-enable tick, with no derived clock. It adds an input glitch filter, an extended 16-bit address mode, full address/command output, a repeat-validity window and coded error reporting. It sits between the IR receiver pin and the car's command decoder.

## Interface
- `CLK_FREQ`, 50_000_000: `sys_clk` frequency in Hz. The tick divider is `CLK_DIV = CLK_FREQ/8000`, which must be ≥ 2. One tick = 125 µs.
- `FILT_LEN`, 3: number of consecutive agreeing tick samples needed to change the filtered level. Range 1..8.
- `EXT_ADDR`, 0: address mode.
  - 0: byte1 must equal ~byte0; `addr = {8'h00, byte0}`.
  - 1: 16-bit address, no address check; `addr = {byte1, byte0}`.
- `REPEAT_WIN`, 880: number of ticks (110 ms) after a valid frame or repeat during which a repeat code is accepted.
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `remote_in`  in  1  raw IR receiver output, idle high, asynchronous.
- `frame_valid`  out  1  one-cycle pulse: a frame passed all checks.
- `repeat_valid`  out  1  one-cycle pulse: a valid repeat code was received inside the window.
- `err`  out  1  one-cycle pulse: decode aborted.
- `err_code`  out  2  cause of the last error, held until the next `err`. 1 = timing, 2 = checksum, 3 = orphan repeat.
- `addr`  out  16  last valid address.
- `cmd`  out  8  last valid command.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- **Input path**
  - `remote_in` passes through a 2-flop synchroniser.
  - On each tick the synchronised value is shifted into a FILT_LEN-deep sample register. The filtered level changes only when all samples agree.
  - Rise and fall events are single-tick flags derived from the filtered level.
- **Tick and counter**
  - The tick counter counts 0..CLK_DIV-1 and pulses `tick` for one cycle at wrap.
  - An 8-bit phase counter counts ticks, saturates at 255, and clears on every accepted edge.
- **FSM.** All transitions happen on tick cycles only.
  - IDLE: on filtered fall → LEAD_LOW.
  - LEAD_LOW: a rise with count 69..75 → LEAD_HIGH. A rise outside that range, or count reaching 76, is a timing error.
  - LEAD_HIGH: on a fall, count 33..38 → BIT_LOW with bit index 0; count 15..20 → RPT_STOP. Any other count, or count reaching 39, is a timing error.
  - BIT_LOW: a rise with count 2..6 → BIT_HIGH if the bit index is < 32, otherwise frame check. Any other count, or count reaching 7, is a timing error.
  - BIT_HIGH: on a fall, count 2..6 shifts in 0 and count 10..15 shifts in 1, LSB first, then index+1 → BIT_LOW. Any other count, or count reaching 16, is a timing error.
  - RPT_STOP: a rise with count 2..6 → repeat check. Any other count, or count reaching 7, is a timing error.
- **Frame check**
  - Bytes arrive in order b0 (bits 0..7) through b3 (bits 24..31).
  - Pass condition: `b3 == ~b2`, and `b1 == ~b0` when EXT_ADDR=0.
  - On pass: update `addr`/`cmd`, pulse `frame_valid`, load the repeat timer with REPEAT_WIN.
  - On fail: `err_code` = 2; `addr`/`cmd` are unchanged.
- **Repeat check**
  - If the repeat timer is non-zero: pulse `repeat_valid` and reload the timer.
  - Otherwise: `err_code` = 3.
  - The repeat timer decrements by 1 per tick while non-zero.
- **Errors**
  - On any error: pulse `err`, clear the shift register, return to IDLE.
  - IDLE re-arms only on a filtered fall, never on a low level, so a mid-burst abort cannot restart inside data.
- **Simultaneous events**
  - Repeat-timer expiry on the same tick as a repeat acceptance: the acceptance wins and the timer is reloaded.
- **Reset**
  - All outputs, the FSM, counters, shift register and repeat timer go to zero/IDLE.
  - The filter samples reset to all-ones (idle high).
  - Reset mid-frame discards the partial frame.

## Timing
- Output pulses are exactly one `sys_clk` cycle wide. They assert on the cycle after the deciding tick.
- `addr`/`cmd`/`err_code` update on the same cycle as their pulse.
- Latency from a `remote_in` edge to the filtered event: 2 cycles + (FILT_LEN-1) to FILT_LEN ticks.
- `frame_valid` follows the rise that ends the stop mark after bit 31 by one tick-decision plus one cycle.
- `busy` goes high on the cycle after the tick that leaves IDLE, and low on the cycle after the return to IDLE.
- A timing error is reported no later than one tick after the counter passes the phase maximum, even with no edge present.

## Test plan
- EXT_ADDR=0, frame b0=0x00, b1=0xFF, cmd=0x45/0xBA → one `frame_valid`, addr=0x0000, cmd=0x45, no `err`.
- Valid repeat code 40 ms after the frame → `repeat_valid`, addr/cmd unchanged. A repeat 200 ms after the last valid event → `err`, err_code=3, no `repeat_valid`.
- Frame with b3=0xBB → `err`, err_code=2, addr/cmd keep previous values. Leader low of 48 ticks → err_code=1. Leader held low 40 ms → err_code=1 by tick 77, `busy` drops.
- FILT_LEN=3, 1-tick low glitch inside the 4.5 ms leader high → ignored, frame decodes normally. The same glitch with FILT_LEN=1 → err_code=1.
- EXT_ADDR=1, b0=0x34, b1=0x12, cmd=0x0C → addr=0x1234, cmd=0x0C, `frame_valid`.
- `sys_rst_n` pulsed low at bit 17 of a frame → all outputs 0 immediately. The next complete frame decodes correctly.
